fpmul_arbiter: RTL
==================

# fpmul_arbiter

Round-robin arbiter and sequencer that shares one FPMUL instance between `NREQ` requesters. It accepts multiply requests on a per-requester valid/grant handshake and latches the operands. It issues a correctly timed single-cycle `Start` to FPMUL, captures the product and flags on FPMUL `Done`, and returns them to the originating requester. It sits between the requester clients and FPMUL, shares their clock and reset, and includes a watchdog that faults the block if FPMUL never completes.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `TIMEOUT`, default 16: maximum BUSY cycles allowed before the watchdog fires.

Ports:
- `Clk`  in  1  clock, rising edge.
- `Rst`  in  1  asynchronous, active-high reset. It is the same net that resets FPMUL.
- `req`  in  NREQ  request per requester. The requester holds it high with operands stable until it sees its `gnt` bit.
- `req_a`  in  32*NREQ  operand A, slice i = `[32i+31:32i]`.
- `req_b`  in  32*NREQ  operand B, same slicing.
- `gnt`  out  NREQ  one-hot, one-cycle acceptance pulse.
- `rsp_valid`  out  NREQ  one-hot, one-cycle result pulse to the originating requester.
- `rsp_p`  out  32  product. Held until the next capture.
- `rsp_flags`  out  6  {OF,UF,NaNF,InfF,DNF,ZF}. Held until the next capture.
- `rsp_err`  out  1  set with `rsp_valid` when the result is a timeout.
- `busy`  out  1  high when state is ISSUE, BUSY or RESP.
- `fault`  out  1  sticky watchdog fault. Cleared only by `Rst`.
- `fpm_start`, `fpm_a[31:0]`, `fpm_b[31:0]`  out: drive FPMUL `Start`, `A`, `B`.
- `fpm_done`, `fpm_p[31:0]`, `fpm_of`, `fpm_uf`, `fpm_nanf`, `fpm_inff`, `fpm_dnf`, `fpm_zf`  in: from FPMUL.

## Operation
- States: COOL, IDLE, ISSUE, BUSY, RESP, HALT. The reset state is COOL.
- **COOL**: covers the one cycle FPMUL spends in its reset/clear state.
  - Entered after reset and after every RESP.
  - FPMUL ignores `Start` in this cycle, so COOL never issues. It goes to IDLE unconditionally.
- **IDLE**: if `req` is nonzero, pick the winner by round-robin.
  - Search starts at `(last+1) mod NREQ`. `last` resets to NREQ-1, so requester 0 has the highest priority after reset.
  - Latch `req_a`/`req_b` of the winner into `fpm_a`/`fpm_b`, record its index as `cur` and as `last`, then go to ISSUE.
  - With no request, stay in IDLE.
- **ISSUE**: `gnt[cur]`=1 and `fpm_start`=1 for exactly this cycle. Clear the watchdog counter and go to BUSY.
- **BUSY**: `fpm_a`/`fpm_b` are held stable. The watchdog counter increments every cycle.
  - If `fpm_done`=1: capture `fpm_p` and the six flags, set `rsp_err`=0, go to RESP.
  - Else if the counter reaches TIMEOUT: `rsp_p`=0, flags=0, `rsp_err`=1, set `fault`, go to RESP.
- **RESP**: `rsp_valid[cur]`=1 for one cycle. Go to HALT if `fault`, else to COOL.
- **HALT**: no grants or starts. `req` is ignored. Exit only on `Rst`.
- `fpm_done` sampled in any state other than BUSY is ignored. This covers stale completions.
- `gnt`, `rsp_valid`, `fpm_start`, `busy` are registered Moore outputs, decoded from state and `cur`.
- Widths:
  - `cur`/`last`: $clog2(NREQ) bits.
  - Watchdog counter: $clog2(TIMEOUT+1) bits, no wrap.
  - `rsp_flags` bit 5 = OF, bit 0 = ZF.
- Reset values: all outputs 0; `fpm_a`=`fpm_b`=0; `last`=NREQ-1; `cur`=0; counter 0.

## Timing
- A request present in IDLE at cycle t gives:
  - `gnt` and `fpm_start` at t+1.
  - FPMUL `Done` at t+9 on the normal path, or t+6 on the NaN/Inf/Zero path.
  - `rsp_valid` at t+10 or t+7.
  - COOL at t+11 or t+8, IDLE the cycle after.
  - Earliest next `fpm_start` at t+13 or t+10.
- Sustained throughput on the normal path is one operation per 12 cycles.
- After `Rst` deasserts, the earliest `gnt`/`fpm_start` is cycle 2: COOL, then IDLE, then ISSUE.
- A requester may deassert `req` in the cycle after its `gnt`. A new request from the same requester may be raised before `rsp_valid`, and it is queued via `req`.
- Simultaneous `fpm_done` and watchdog expiry in the same BUSY cycle: done wins and no fault is raised.
- `Rst` mid-operation resets both blocks. No `rsp_valid` is produced for the lost operation.

## Test plan
- Reset → all outputs 0. Hold `req[0]`=1 through reset → `gnt[0]` at the 3rd cycle after release, never earlier.
- `req[0]`, A=0x3FC00000 (1.5), B=0x40000000 (2.0) → `gnt[0]` at t+1; `rsp_valid[0]` at t+10; `rsp_p`=0x40400000; `rsp_flags`=0; `rsp_err`=0.
- `req`=4'b1111 held continuously, distinct operands per requester → grant order 0,1,2,3,0, starts 12 cycles apart, each `rsp_valid` one-hot to the matching requester with the matching product.
- `req[2]`, A=0x7F800000 (+Inf), B=0x00000000 → `rsp_valid[2]` at t+7 with NaNF=1. Also check `fpm_start` is never high in COOL.
- FPMUL stub that never asserts `fpm_done` → `rsp_valid[cur]` with `rsp_err`=1 and `rsp_p`=0 at t+2+TIMEOUT; `fault`=1; no `gnt` afterwards while `req` stays high; `Rst` clears `fault`.
- Stub asserts `fpm_done` during IDLE and COOL → no capture, no `rsp_valid`. Done and watchdog expiry in the same cycle → normal response, `fault`=0.

Source files
------------

// File: rtl/fpmul_arbiter.sv
// fpmul_arbiter: round-robin sharing of one FPMUL between NREQ requesters, with
// start sequencing, result return and a sticky watchdog for missing completions.
//
// state | meaning
// COOL  | FPMUL in its clear cycle after reset or a response; never issues
// IDLE  | waiting for a request; round-robin pick and operand latch
// ISSUE | gnt + fpm_start pulse, watchdog cleared
// BUSY  | operands held, waiting for fpm_done or watchdog expiry
// RESP  | rsp_valid pulse to the owning requester
// HALT  | watchdog fault; frozen until Rst
module fpmul_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NREQ-1:0]    req,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [31:0]        rsp_p,
  output logic [5:0]         rsp_flags,
  output logic               rsp_err,
  output logic               busy,
  output logic               fault,
  output logic               fpm_start,
  output logic [31:0]        fpm_a,
  output logic [31:0]        fpm_b,
  input  logic               fpm_done,
  input  logic [31:0]        fpm_p,
  input  logic               fpm_of,
  input  logic               fpm_uf,
  input  logic               fpm_nanf,
  input  logic               fpm_inff,
  input  logic               fpm_dnf,
  input  logic               fpm_zf
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);
  localparam logic [CW-1:0] WDOG_MAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {COOL, IDLE, ISSUE, BUSY, RESP, HALT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   cur_q, cur_d;
  logic [IW-1:0]   last_q, last_d;
  logic [31:0]     fpm_a_q, fpm_a_d;
  logic [31:0]     fpm_b_q, fpm_b_d;
  logic [CW-1:0]   wdog_q, wdog_d;
  logic [CW-1:0]   wdog_inc;
  logic [31:0]     rsp_p_q, rsp_p_d;
  logic [5:0]      rsp_flags_q, rsp_flags_d;
  logic            rsp_err_q, rsp_err_d;
  logic            fault_q, fault_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic            fpm_start_q, fpm_start_d;
  logic            busy_q, busy_d;

  logic [31:0]     op_a [NREQ];
  logic [31:0]     op_b [NREQ];
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   probe;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_a[g] = req_a[32*g +: 32];
    assign op_b[g] = req_b[32*g +: 32];
  end

  // Search begins one past the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    probe     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      probe = IW'((int'(last_q) + i) % NREQ);
      if (!win_found && req[probe]) begin
        win_found = 1'b1;
        win_idx   = probe;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    fpm_a_d     = fpm_a_q;
    fpm_b_d     = fpm_b_q;
    wdog_d      = wdog_q;
    rsp_p_d     = rsp_p_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    fault_d     = fault_q;
    wdog_inc    = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + CW'(1);

    case (state_q)
      COOL: state_d = IDLE;
      IDLE: begin
        if (win_found) begin
          cur_d   = win_idx;
          last_d  = win_idx;
          fpm_a_d = op_a[win_idx];
          fpm_b_d = op_b[win_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = BUSY;
      end
      BUSY: begin
        wdog_d = wdog_inc;
        // A completion in the expiry cycle still counts as a good result.
        if (fpm_done) begin
          rsp_p_d     = fpm_p;
          rsp_flags_d = {fpm_of, fpm_uf, fpm_nanf, fpm_inff, fpm_dnf, fpm_zf};
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (wdog_inc == WDOG_MAX) begin
          rsp_p_d     = '0;
          rsp_flags_d = '0;
          rsp_err_d   = 1'b1;
          fault_d     = 1'b1;
          state_d     = RESP;
        end
      end
      RESP:    state_d = fault_q ? HALT : COOL;
      HALT:    state_d = HALT;
      default: state_d = COOL;
    endcase

    gnt_d       = '0;
    rsp_valid_d = '0;
    if (state_d == ISSUE) gnt_d[cur_d] = 1'b1;
    if (state_d == RESP)  rsp_valid_d[cur_d] = 1'b1;
    fpm_start_d = (state_d == ISSUE);
    busy_d      = (state_d == ISSUE) || (state_d == BUSY) || (state_d == RESP);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= COOL;
      cur_q       <= '0;
      last_q      <= LAST_RST;
      fpm_a_q     <= '0;
      fpm_b_q     <= '0;
      wdog_q      <= '0;
      rsp_p_q     <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
      fault_q     <= 1'b0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      fpm_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      fpm_a_q     <= fpm_a_d;
      fpm_b_q     <= fpm_b_d;
      wdog_q      <= wdog_d;
      rsp_p_q     <= rsp_p_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
      fault_q     <= fault_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      fpm_start_q <= fpm_start_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign fpm_start = fpm_start_q;
  assign fpm_a     = fpm_a_q;
  assign fpm_b     = fpm_b_q;

endmodule
